// File: rtl/imm_ext_sequencer.sv
// Decode-stage sequencer for the shared 32-bit immediate extender.
// Accepts one instruction, drives the extender, then issues the operand.
module imm_ext_sequencer #(
   parameter int EXT_LATENCY = 1,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [31:0]      instr,
   output logic [1:0]       ext_sel,
   output logic [31:0]      ext_in,
   input  logic [31:0]      ext_result,
   output logic             op_valid,
   input  logic             op_ready,
   output logic [31:0]      op_imm,
   output logic             op_use_imm,
   output logic [5:0]       op_opcode,
   output logic             op_illegal,
   output logic [CNT_W-1:0] issue_count,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [1:0] SEL_ZERO = 2'b00;
   localparam logic [1:0] SEL_SIGN = 2'b01;
   localparam logic [1:0] SEL_LUI  = 2'b10;
   localparam logic [3:0] LAT      = 4'(EXT_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EXTEND = 2'd1,
      S_OUTPUT = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [3:0] lat_cnt;
   logic       accept;
   logic       issue;
   logic       lat_done;
   logic       dec_imm;
   logic       dec_legal;
   logic [1:0] dec_sel;

   assign accept   = instr_valid & instr_ready;
   assign issue    = op_valid & op_ready;
   assign lat_done = (state == S_EXTEND) && (lat_cnt == LAT);

   // Classify the incoming opcode into extension mode / legality
   always_comb begin
      dec_imm   = 1'b0;
      dec_legal = 1'b1;
      dec_sel   = SEL_ZERO;
      case (instr[31:26])
         6'h0C, 6'h0D, 6'h0E: begin
            dec_imm = 1'b1;
            dec_sel = SEL_ZERO;
         end
         6'h04, 6'h05, 6'h08, 6'h09,
         6'h0A, 6'h0B, 6'h23, 6'h2B: begin
            dec_imm = 1'b1;
            dec_sel = SEL_SIGN;
         end
         6'h0F: begin
            dec_imm = 1'b1;
            dec_sel = SEL_LUI;
         end
         6'h00, 6'h02, 6'h03: begin
            dec_imm = 1'b0;
         end
         default: begin
            dec_legal = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (dec_imm) begin
                  state_nxt = S_EXTEND;
               end else begin
                  state_nxt = S_OUTPUT;
               end
            end
         end
         S_EXTEND: begin
            if (lat_done) begin
               state_nxt = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            if (op_ready) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the state
   always_comb begin
      instr_ready = (state == S_IDLE);
      op_valid    = (state == S_OUTPUT);
   end

   // Extender latency counter, runs 1..EXT_LATENCY while in EXTEND
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lat_cnt <= 4'd0;
      end else if (accept && dec_imm) begin
         lat_cnt <= 4'd1;
      end else if (lat_done) begin
         lat_cnt <= 4'd0;
      end else if (state == S_EXTEND) begin
         lat_cnt <= lat_cnt + 4'd1;
      end
   end

   // Extender controls only change on accepting an immediate opcode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ext_sel <= SEL_ZERO;
         ext_in  <= 32'd0;
      end else if (accept && dec_imm) begin
         ext_sel <= dec_sel;
         ext_in  <= {16'd0, instr[15:0]};
      end
   end

   // Capture the issued operand fields
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_imm     <= 32'd0;
         op_use_imm <= 1'b0;
         op_opcode  <= 6'd0;
         op_illegal <= 1'b0;
      end else if (accept) begin
         op_imm     <= 32'd0;
         op_use_imm <= dec_imm;
         op_opcode  <= instr[31:26];
         op_illegal <= ~dec_legal;
      end else if (lat_done) begin
         op_imm     <= ext_result;
      end
   end

   // Issue statistics, wrapping silently
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         issue_count   <= '0;
         illegal_count <= '0;
      end else if (issue) begin
         issue_count <= issue_count + CNT_W'(1);
         if (op_illegal) begin
            illegal_count <= illegal_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_imm_ext_sequencer.sv
// Directed bench for imm_ext_sequencer.
// Instance a: EXT_LATENCY=1, CNT_W=16. Instance b: EXT_LATENCY=3, CNT_W=4.
module tb_imm_ext_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst[2];
   logic        iv[2];
   logic [31:0] ins[2];
   logic        ordy[2];

   logic        ir_a, opv_a, use_a, ill_a;
   logic [1:0]  sel_a;
   logic [31:0] ein_a, eres_a, imm_a;
   logic [5:0]  opc_a;
   logic [15:0] ic_a, lc_a;

   logic        ir_b, opv_b, use_b, ill_b;
   logic [1:0]  sel_b;
   logic [31:0] ein_b, eres_b, imm_b;
   logic [5:0]  opc_b;
   logic [3:0]  ic_b, lc_b;

   int passed = 0;
   int total  = 0;

   function automatic logic [31:0] ext_fn(input logic [1:0] s, input logic [31:0] x);
      case (s)
         2'b00:   return x;
         2'b01:   return {{16{x[15]}}, x[15:0]};
         2'b10:   return {x[15:0], 16'h0000};
         default: return 32'h0;
      endcase
   endfunction

   // Extender models: combinational for latency 1, two-register pipe for latency 3
   assign eres_a = ext_fn(sel_a, ein_a);
   logic [31:0] pipe1, pipe2;
   always @(posedge clk) begin
      pipe1 <= ext_fn(sel_b, ein_b);
      pipe2 <= pipe1;
   end
   assign eres_b = pipe2;

   imm_ext_sequencer #(.EXT_LATENCY(1), .CNT_W(16)) dut_a (
      .clk(clk), .reset(rst[0]),
      .instr_valid(iv[0]), .instr_ready(ir_a), .instr(ins[0]),
      .ext_sel(sel_a), .ext_in(ein_a), .ext_result(eres_a),
      .op_valid(opv_a), .op_ready(ordy[0]), .op_imm(imm_a),
      .op_use_imm(use_a), .op_opcode(opc_a), .op_illegal(ill_a),
      .issue_count(ic_a), .illegal_count(lc_a)
   );

   imm_ext_sequencer #(.EXT_LATENCY(3), .CNT_W(4)) dut_b (
      .clk(clk), .reset(rst[1]),
      .instr_valid(iv[1]), .instr_ready(ir_b), .instr(ins[1]),
      .ext_sel(sel_b), .ext_in(ein_b), .ext_result(eres_b),
      .op_valid(opv_b), .op_ready(ordy[1]), .op_imm(imm_b),
      .op_use_imm(use_b), .op_opcode(opc_b), .op_illegal(ill_b),
      .issue_count(ic_b), .illegal_count(lc_b)
   );

   function automatic logic g_opv(input int d);
      return (d == 1) ? opv_b : opv_a;
   endfunction

   // Handshake one instruction; lat = cycles from handshake edge until op_valid seen
   task automatic issue(input int d, input logic [31:0] w, output int lat);
      @(negedge clk);
      ins[d] = w;
      iv[d]  = 1'b1;
      @(posedge clk);
      #1 iv[d] = 1'b0;
      lat = 1;
      while (!g_opv(d) && lat < 40) begin
         @(posedge clk);
         #1 lat++;
      end
   endtask

   task automatic complete(input int d);
      @(negedge clk);
      ordy[d] = 1'b1;
      @(posedge clk);
      #1 ordy[d] = 1'b0;
   endtask

   task automatic test_reset;
      rst[0] = 1'b1; rst[1] = 1'b1;
      iv[0] = 1'b0; iv[1] = 1'b0;
      ins[0] = '0; ins[1] = '0;
      ordy[0] = 1'b0; ordy[1] = 1'b0;
      #1;
      total++; if (ir_a !== 1'b1) $display("FAIL rst_ready_a got %b want 1", ir_a); else passed++;
      total++; if (opv_a !== 1'b0) $display("FAIL rst_valid_a got %b want 0", opv_a); else passed++;
      total++; if (ic_a !== 16'd0 || lc_a !== 16'd0) $display("FAIL rst_cnt_a got %h/%h want 0/0", ic_a, lc_a); else passed++;
      total++; if ({imm_a, use_a, opc_a, ill_a} !== 40'd0) $display("FAIL rst_op_a got %h want 0", {imm_a, use_a, opc_a, ill_a}); else passed++;
      total++; if ({sel_a, ein_a} !== 34'd0) $display("FAIL rst_ext_a got %h want 0", {sel_a, ein_a}); else passed++;
      total++; if (ir_b !== 1'b1 || opv_b !== 1'b0) $display("FAIL rst_hs_b got %b%b want 10", ir_b, opv_b); else passed++;
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
   endtask

   task automatic test_zero_ext;
      int lat;
      issue(0, 32'h3508_8000, lat);
      total++; if (lat !== 2) $display("FAIL zext_lat got %0d want 2", lat); else passed++;
      total++; if (sel_a !== 2'b00) $display("FAIL zext_sel got %b want 00", sel_a); else passed++;
      total++; if (ein_a !== 32'h0000_8000) $display("FAIL zext_in got %h want 00008000", ein_a); else passed++;
      total++; if (imm_a !== 32'h0000_8000) $display("FAIL zext_imm got %h want 00008000", imm_a); else passed++;
      total++; if (use_a !== 1'b1 || opc_a !== 6'h0D || ill_a !== 1'b0) $display("FAIL zext_flags got %b %h %b want 1 0d 0", use_a, opc_a, ill_a); else passed++;
      complete(0);
      total++; if (ic_a !== 16'd1) $display("FAIL zext_count got %0d want 1", ic_a); else passed++;
      total++; if (opv_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL zext_idle got %b%b want 01", opv_a, ir_a); else passed++;
   endtask

   task automatic test_sign_ext;
      int lat;
      issue(0, 32'h2108_FFFC, lat);
      total++; if (lat !== 2) $display("FAIL sext_lat got %0d want 2", lat); else passed++;
      total++; if (sel_a !== 2'b01) $display("FAIL sext_sel got %b want 01", sel_a); else passed++;
      total++; if (imm_a !== 32'hFFFF_FFFC) $display("FAIL sext_imm got %h want fffffffc", imm_a); else passed++;
      complete(0);
      total++; if (ic_a !== 16'd2) $display("FAIL sext_count got %0d want 2", ic_a); else passed++;
   endtask

   task automatic test_lui;
      int lat;
      issue(0, 32'h3C01_1234, lat);
      total++; if (lat !== 2) $display("FAIL lui_lat got %0d want 2", lat); else passed++;
      total++; if (sel_a !== 2'b10) $display("FAIL lui_sel got %b want 10", sel_a); else passed++;
      total++; if (imm_a !== 32'h1234_0000) $display("FAIL lui_imm got %h want 12340000", imm_a); else passed++;
      complete(0);
   endtask

   task automatic test_rtype;
      int lat;
      issue(0, 32'h0109_5020, lat);
      total++; if (lat !== 1) $display("FAIL rtype_lat got %0d want 1", lat); else passed++;
      total++; if (use_a !== 1'b0 || imm_a !== 32'd0) $display("FAIL rtype_op got %b %h want 0 0", use_a, imm_a); else passed++;
      total++; if (sel_a !== 2'b10 || ein_a !== 32'h0000_1234) $display("FAIL rtype_ext_hold got %b %h want 10 00001234", sel_a, ein_a); else passed++;
      complete(0);
      total++; if (ic_a !== 16'd4) $display("FAIL rtype_count got %0d want 4", ic_a); else passed++;
   endtask

   task automatic test_backpressure;
      int lat;
      int bad;
      issue(0, 32'h3408_0055, lat);
      total++; if (lat !== 2 || imm_a !== 32'h0000_0055) $display("FAIL bp_first got %0d %h want 2 00000055", lat, imm_a); else passed++;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         iv[0]  = 1'b1;
         ins[0] = 32'hFC00_0000;
         @(posedge clk);
         #1;
         if (opv_a !== 1'b1 || ir_a !== 1'b0 || imm_a !== 32'h55 || opc_a !== 6'h0D) bad++;
      end
      total++; if (bad !== 0) $display("FAIL bp_stable got %0d bad cycles want 0", bad); else passed++;
      @(negedge clk);
      iv[0] = 1'b0;
      complete(0);
      total++; if (ic_a !== 16'd5 || lc_a !== 16'd0) $display("FAIL bp_count got %0d/%0d want 5/0", ic_a, lc_a); else passed++;
      @(posedge clk);
      #1;
      total++; if (opv_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL bp_no_dup got %b%b want 01", opv_a, ir_a); else passed++;
   endtask

   task automatic test_illegal;
      int lat;
      issue(0, 32'hFC00_0000, lat);
      total++; if (lat !== 1) $display("FAIL ill_lat got %0d want 1", lat); else passed++;
      total++; if (ill_a !== 1'b1 || use_a !== 1'b0 || imm_a !== 32'd0 || opc_a !== 6'h3F) $display("FAIL ill_op got %b %b %h %h want 1 0 0 3f", ill_a, use_a, imm_a, opc_a); else passed++;
      complete(0);
      total++; if (ic_a !== 16'd6 || lc_a !== 16'd1) $display("FAIL ill_count got %0d/%0d want 6/1", ic_a, lc_a); else passed++;
   endtask

   task automatic test_ready_early;
      int lat;
      ordy[0] = 1'b1;
      issue(0, 32'h2409_0001, lat);
      total++; if (lat !== 2 || imm_a !== 32'd1) $display("FAIL early_op got %0d %h want 2 00000001", lat, imm_a); else passed++;
      @(posedge clk);
      #1;
      total++; if (opv_a !== 1'b0 || ic_a !== 16'd7) $display("FAIL early_one_cycle got %b %0d want 0 7", opv_a, ic_a); else passed++;
      ordy[0] = 1'b0;
   endtask

   task automatic test_reset_mid_output;
      int lat;
      issue(0, 32'h0109_5020, lat);
      total++; if (opv_a !== 1'b1) $display("FAIL rso_pre got %b want 1", opv_a); else passed++;
      @(negedge clk);
      rst[0] = 1'b1;
      #1;
      total++; if (opv_a !== 1'b0 || ir_a !== 1'b1) $display("FAIL rso_async got %b%b want 01", opv_a, ir_a); else passed++;
      total++; if (ic_a !== 16'd0 || lc_a !== 16'd0) $display("FAIL rso_cnt got %0d/%0d want 0/0", ic_a, lc_a); else passed++;
      @(negedge clk);
      rst[0] = 1'b0;
      issue(0, 32'h3508_8000, lat);
      total++; if (lat !== 2 || imm_a !== 32'h8000) $display("FAIL rso_next got %0d %h want 2 00008000", lat, imm_a); else passed++;
      complete(0);
      total++; if (ic_a !== 16'd1) $display("FAIL rso_count got %0d want 1", ic_a); else passed++;
   endtask

   task automatic test_sign_latency3;
      int lat;
      issue(1, 32'h2108_FFFC, lat);
      total++; if (lat !== 4) $display("FAIL lat3_lat got %0d want 4", lat); else passed++;
      total++; if (sel_b !== 2'b01 || imm_b !== 32'hFFFF_FFFC) $display("FAIL lat3_imm got %b %h want 01 fffffffc", sel_b, imm_b); else passed++;
      complete(1);
      total++; if (ic_b !== 4'd1) $display("FAIL lat3_count got %0d want 1", ic_b); else passed++;
   endtask

   task automatic test_reset_mid_extend;
      int lat;
      @(negedge clk);
      ins[1] = 32'h3C01_1234;
      iv[1]  = 1'b1;
      @(posedge clk);
      #1 iv[1] = 1'b0;
      total++; if (ir_b !== 1'b0) $display("FAIL rse_busy got %b want 0", ir_b); else passed++;
      @(posedge clk);
      #2 rst[1] = 1'b1;
      #1;
      total++; if (ir_b !== 1'b1 || opv_b !== 1'b0) $display("FAIL rse_async got %b%b want 10", ir_b, opv_b); else passed++;
      total++; if (ic_b !== 4'd0 || lc_b !== 4'd0) $display("FAIL rse_cnt got %0d/%0d want 0/0", ic_b, lc_b); else passed++;
      @(negedge clk);
      rst[1] = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      total++; if (opv_b !== 1'b0) $display("FAIL rse_discard got %b want 0", opv_b); else passed++;
      issue(1, 32'h3C01_1234, lat);
      total++; if (lat !== 4 || imm_b !== 32'h1234_0000) $display("FAIL rse_next got %0d %h want 4 12340000", lat, imm_b); else passed++;
      complete(1);
      total++; if (ic_b !== 4'd1) $display("FAIL rse_count got %0d want 1", ic_b); else passed++;
   endtask

   task automatic test_wrap;
      int lat;
      int slow;
      @(negedge clk);
      rst[1] = 1'b1;
      @(negedge clk);
      rst[1] = 1'b0;
      ordy[1] = 1'b1;
      slow = 0;
      for (int i = 0; i < 17; i++) begin
         issue(1, 32'hFC00_0000, lat);
         if (lat !== 1) slow++;
         @(posedge clk);
      end
      #1 ordy[1] = 1'b0;
      total++; if (slow !== 0) $display("FAIL wrap_lat got %0d slow issues want 0", slow); else passed++;
      total++; if (ic_b !== 4'd1) $display("FAIL wrap_issue got %0d want 1", ic_b); else passed++;
      total++; if (lc_b !== 4'd1) $display("FAIL wrap_illegal got %0d want 1", lc_b); else passed++;
   endtask

   initial begin
      test_reset();
      test_zero_ext();
      test_sign_ext();
      test_lui();
      test_rtype();
      test_backpressure();
      test_illegal();
      test_ready_early();
      test_reset_mid_output();
      test_sign_latency3();
      test_reset_mid_extend();
      test_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
